mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage memory sequencer for the pipelined LC-3b datapath. It consumes the decoded control
//  word (mem_read, mem_write, is_ldi, is_sti, is_ldb_stb) and the EX address, and drives the
//  data-memory port. It sequences single (LDR/STR/LDB/STB/TRAP) and double (LDI/STI) accesses,
//  formats byte data, and stalls the pipeline until the final dmem_resp arrives.
// PARAMETERS
//  DATA_W  16  data/address width (LC-3b word); only 16 is supported
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  valid_i      in   1       EX/MEM register holds a live instruction
//  mem_read_i   in   1       control word mem_read
//  mem_write_i  in   1       control word mem_write
//  is_ldi_i     in   1       control word is_ldi
//  is_sti_i     in   1       control word is_sti
//  is_byte_i    in   1       control word is_ldb_stb
//  addr_i       in   16      effective address (ALU result)
//  sdata_i      in   16      store source register value
//  advance_i    in   1       MEM/WB register loads this cycle (global pipeline enable)
//  dmem_rdata   in   16      memory read data
//  dmem_resp    in   1       memory completes current request (single-cycle pulse)
//  dmem_address out  16      memory address
//  dmem_read    out  1       read request, held until dmem_resp
//  dmem_write   out  1       write request, held until dmem_resp
//  dmem_wdata   out  16      write data
//  dmem_byte_en out  2       byte enables
//  load_data_o  out  16      formatted load data to regfilemux
//  stall_o      out  1       hold all upstream stages
// BEHAVIOUR
//  States: IDLE, IND, HOLD. Reset -> IDLE; ind_addr_q = 0; data_q = 0. While reset is high,
//   dmem_read, dmem_write, and stall_o are 0, and load_data_o is 0.
//  acc = valid_i & (mem_read_i | mem_write_i). ind = is_ldi_i | is_sti_i.
//  IDLE: if acc, issue the first access combinationally in the same cycle.
//   - Word op: address = {addr_i[15:1], 1'b0}; byte_en = 11.
//   - LDI/STI first access is a word read (STI control sets mem_read), even though sti is set.
//   - STB: address = addr_i; byte_en = addr_i[0] ? 10 : 01; wdata = {sdata_i[7:0], sdata_i[7:0]}.
//   - Word store: wdata = sdata_i.
//   On dmem_resp:
//   - if ind: ind_addr_q <= dmem_rdata; -> IND.
//   - else final completion (see below).
//  IND: issue a word access at {ind_addr_q[15:1], 0}: read for LDI, write of sdata_i for STI.
//   dmem_resp -> final completion.
//  Final completion cycle: stall_o = 0. load_data_o = formatted dmem_rdata, combinationally.
//   data_q <= formatted data. Next state = advance_i ? IDLE : HOLD.
//  HOLD: no request issued; stall_o = 0; load_data_o = data_q. advance_i -> IDLE.
//   HOLD guarantees no re-issue while another stage stalls.
//  stall_o = (IDLE & acc & ~(dmem_resp & ~ind)) | (IND & ~dmem_resp). Otherwise 0.
//  Load formatting:
//   - LDB: sign-extend dmem_rdata[15:8] if addr_i[0], else dmem_rdata[7:0].
//   - Word: dmem_rdata unchanged.
//  Latency: with zero-wait memory, a single access completes in its MEM cycle (0 stall cycles).
//   Indirect costs 1 extra cycle plus wait states.
//  IDLE with no acc: dmem_read = dmem_write = 0 and load_data_o = data_q.
//  dmem_read/dmem_write are never both 1. The request is stable from issue until dmem_resp.
//  Reset mid-IND/HOLD: abort to IDLE next edge; the request drops in the reset cycle.
//   An in-flight memory response is ignored.
// TESTING
//  1 LDR addr=0x1002, resp same cycle, rdata=0xBEEF -> load_data_o=0xBEEF, stall_o never 1.
//  2 STR addr=0x2000, sdata=0x1234, resp after 3 cycles -> stall_o=1 for 3 cycles, then 0.
//    write held constant with wdata=0x1234, byte_en=11.
//  3 LDB addr=0x3001, rdata=0x80FF -> load_data_o=0xFF80.
//    STB addr=0x3001, sdata=0x00AB -> byte_en=10, wdata=0xABAB.
//  4 LDI addr=0x4000: first rdata=0x5000, then rdata at 0x5000 = 0x7777.
//    -> second read addr=0x5000, load_data_o=0x7777, stall_o high through first resp.
//  5 STI addr=0x4000 -> read at 0x4000 returns 0x6000 -> write 0x6000 with sdata.
//    advance_i low 2 cycles after completion -> HOLD, no further dmem_read/dmem_write.
//  6 Reset asserted while in IND awaiting resp -> dmem_read=0 that cycle.
//    Next cycle state IDLE, stall_o=0, load_data_o=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle between the MEM-stage sequencer and the data memory.
// Latency: none (wires only).
// Backpressure: the memory holds off completion by withholding the dmem_resp pulse.
//
// Ports (master = sequencer, slave = memory):
//   dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_en : master -> slave
//   dmem_rdata, dmem_resp                                         : slave -> master
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [DATA_W-1:0] dmem_wdata;
    logic [1:0]        dmem_byte_en;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_en,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_en,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage sequencer: single and indirect (LDI/STI) data accesses, byte formatting.
// Latency: a single access completes in its MEM cycle on a zero-wait memory; indirect costs +1 cycle plus wait states.
// Backpressure: stall_o holds upstream until the final dmem_resp; HOLD parks the result while advance_i is low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_i               EX/MEM holds a live instruction
//   mem_read_i/_write_i   control word access type
//   is_ldi_i/is_sti_i     indirect access; is_byte_i: LDB/STB
//   addr_i, sdata_i       effective address, store data
//   advance_i             MEM/WB loads this cycle
//   dmem                  data-memory port (master side)
//   load_data_o           formatted load data to regfilemux
//   stall_o               hold all upstream stages
module mem_access_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              is_ldi_i,
    input  logic              is_sti_i,
    input  logic              is_byte_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] sdata_i,
    input  logic              advance_i,
    mem_access_ctrl_if.master dmem,
    output logic [DATA_W-1:0] load_data_o,
    output logic              stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] ind_addr_q;
    logic [DATA_W-1:0] data_q;

    logic              acc;
    logic              ind;
    logic              complete;
    logic [7:0]        rd_byte;
    logic [DATA_W-1:0] fmt_data;

    assign acc = valid_i & (mem_read_i | mem_write_i);
    assign ind = is_ldi_i | is_sti_i;

    // Byte loads only happen on a non-indirect first access; the second
    // access of LDI is always a full word.
    assign rd_byte  = addr_i[0] ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0];
    assign fmt_data = (state_q == IDLE && is_byte_i && !ind) ?
                      {{8{rd_byte[7]}}, rd_byte} : dmem.dmem_rdata;

    always_comb begin
        state_d           = state_q;
        dmem.dmem_read    = 1'b0;
        dmem.dmem_write   = 1'b0;
        dmem.dmem_address = {addr_i[DATA_W-1:1], 1'b0};
        dmem.dmem_wdata   = sdata_i;
        dmem.dmem_byte_en = 2'b11;
        load_data_o       = data_q;
        stall_o           = 1'b0;
        complete          = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (ind) begin
                        // First half of LDI/STI fetches the pointer word,
                        // even for STI.
                        dmem.dmem_read = 1'b1;
                    end else begin
                        dmem.dmem_write = mem_write_i;
                        dmem.dmem_read  = mem_read_i & ~mem_write_i;
                        if (is_byte_i) begin
                            dmem.dmem_address = addr_i;
                            dmem.dmem_byte_en = addr_i[0] ? 2'b10 : 2'b01;
                            dmem.dmem_wdata   = {sdata_i[7:0], sdata_i[7:0]};
                        end
                    end

                    if (dmem.dmem_resp) begin
                        if (ind) begin
                            state_d = IND;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    stall_o = ~(dmem.dmem_resp & ~ind);
                end
            end

            IND: begin
                dmem.dmem_address = {ind_addr_q[DATA_W-1:1], 1'b0};
                dmem.dmem_read    = ~is_sti_i;
                dmem.dmem_write   = is_sti_i;
                if (dmem.dmem_resp) begin
                    complete = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end

            HOLD: begin
                // Result is parked in data_q; nothing re-issues while a
                // downstream stage keeps the pipeline frozen.
                if (advance_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            load_data_o = fmt_data;
            state_d     = advance_i ? IDLE : HOLD;
        end

        // Reset kills the request in the same cycle; a response arriving
        // now is dropped.
        if (reset) begin
            dmem.dmem_read  = 1'b0;
            dmem.dmem_write = 1'b0;
            stall_o         = 1'b0;
            load_data_o     = '0;
            complete        = 1'b0;
            state_d         = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ind_addr_q <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && acc && ind && dmem.dmem_resp) begin
                ind_addr_q <= dmem.dmem_rdata;
            end
            if (complete) begin
                data_q <= fmt_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: memory model with programmable wait states,
// scoreboard of expected bus transactions and load results.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        is_ldi_i;
    logic        is_sti_i;
    logic        is_byte_i;
    logic [15:0] addr_i;
    logic [15:0] sdata_i;
    logic        advance_i;
    logic [15:0] load_data_o;
    logic        stall_o;

    mem_access_ctrl_if #(.DATA_W(16)) mif ();

    mem_access_ctrl #(.DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .is_ldi_i   (is_ldi_i),
        .is_sti_i   (is_sti_i),
        .is_byte_i  (is_byte_i),
        .addr_i     (addr_i),
        .sdata_i    (sdata_i),
        .advance_i  (advance_i),
        .dmem       (mif.master),
        .load_data_o(load_data_o),
        .stall_o    (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 16 words indexed by address[15:12]; responds wait_cfg
    // cycles after a request first appears.
    logic [15:0] mem [0:15];
    logic [3:0]  wcnt;
    int          wait_cfg;
    wire         req = mif.dmem_read | mif.dmem_write;

    assign mif.dmem_resp  = req && (int'(wcnt) == wait_cfg);
    assign mif.dmem_rdata = mem[mif.dmem_address[15:12]];

    always @(posedge clk) begin
        if (req && !mif.dmem_resp) wcnt <= wcnt + 4'd1;
        else                       wcnt <= 4'd0;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        chk_be;
    } bus_t;

    typedef struct {
        logic        chk;
        logic [15:0] val;
    } ld_t;

    bus_t bus_q[$];
    ld_t  load_q[$];

    int          n_checks;
    int          n_fail;
    int          stall_cnt;
    logic        done;
    logic        hold_chk;
    logic [15:0] hold_exp;
    logic        prev_pending;
    logic [35:0] prev_snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bus(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                            input logic [1:0] be, input logic chk_be);
        bus_t e;
        e.wr = wr; e.addr = a; e.wdata = wd; e.be = be; e.chk_be = chk_be;
        bus_q.push_back(e);
    endtask

    task automatic push_load(input logic chk, input logic [15:0] v);
        ld_t e;
        e.chk = chk; e.val = v;
        load_q.push_back(e);
    endtask

    task automatic monitor();
        logic [35:0] snap;
        bus_t        b;
        ld_t         l;
        snap = {mif.dmem_address, mif.dmem_wdata, mif.dmem_byte_en, mif.dmem_read, mif.dmem_write};
        if (!reset) begin
            check("rw_exclusive", {63'd0, mif.dmem_read & mif.dmem_write}, 64'd0);
            if (req && prev_pending) check("req_stable", {28'd0, snap}, {28'd0, prev_snap});
            if (hold_chk) begin
                check("hold_noreq", {63'd0, req}, 64'd0);
                check("hold_data", {48'd0, load_data_o}, {48'd0, hold_exp});
            end
            if (stall_o) stall_cnt++;
            if (req && mif.dmem_resp) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 64'd1, 64'd0);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_addr", {48'd0, mif.dmem_address}, {48'd0, b.addr});
                    check("bus_write", {63'd0, mif.dmem_write}, {63'd0, b.wr});
                    check("bus_read", {63'd0, mif.dmem_read}, {63'd0, ~b.wr});
                    if (b.chk_be) check("bus_byte_en", {62'd0, mif.dmem_byte_en}, {62'd0, b.be});
                    if (b.wr) check("bus_wdata", {48'd0, mif.dmem_wdata}, {48'd0, b.wdata});
                end
                if (!stall_o) begin
                    done = 1'b1;
                    if (load_q.size() == 0) begin
                        check("load_unexpected", 64'd1, 64'd0);
                    end else begin
                        l = load_q.pop_front();
                        if (l.chk) check("load_data", {48'd0, load_data_o}, {48'd0, l.val});
                    end
                end
            end
            prev_pending = req && !mif.dmem_resp;
            prev_snap    = snap;
        end else begin
            prev_pending = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic ldi, input logic sti,
                         input logic byt, input logic [15:0] a, input logic [15:0] sd,
                         input int adv_delay, input int exp_stalls, input logic [15:0] hold_val);
        valid_i     = 1'b1;
        mem_read_i  = rd;
        mem_write_i = wr;
        is_ldi_i    = ldi;
        is_sti_i    = sti;
        is_byte_i   = byt;
        addr_i      = a;
        sdata_i     = sd;
        advance_i   = (adv_delay == 0);
        stall_cnt   = 0;
        done        = 1'b0;
        for (int i = 0; i < 40 && !done; i++) tick();
        if (!done) check("op_timeout", 64'd0, 64'd1);
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stalls));
        if (adv_delay > 0) begin
            hold_chk = 1'b1;
            hold_exp = hold_val;
            for (int i = 0; i < adv_delay - 1; i++) tick();
            advance_i = 1'b1;
            tick();
            hold_chk = 1'b0;
        end
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        is_ldi_i    = 1'b0;
        is_sti_i    = 1'b0;
        is_byte_i   = 1'b0;
        advance_i   = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; stall_cnt = 0;
        done = 1'b0; hold_chk = 1'b0; hold_exp = '0;
        prev_pending = 1'b0; prev_snap = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[1] = 16'hBEEF;
        mem[3] = 16'h80FF;
        mem[4] = 16'h5000;
        mem[5] = 16'h7777;
        mem[6] = 16'h1111;
        wait_cfg = 0;

        // Reset with a live load presented: nothing may leak out.
        reset = 1'b1; valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        is_ldi_i = 1'b0; is_sti_i = 1'b0; is_byte_i = 1'b0;
        addr_i = 16'h1002; sdata_i = 16'h0; advance_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read", {63'd0, mif.dmem_read}, 64'd0);
        check("rst_write", {63'd0, mif.dmem_write}, 64'd0);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_load", {48'd0, load_data_o}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0;
        @(negedge clk);
        check("idle_load", {48'd0, load_data_o}, 64'd0);
        check("idle_noreq", {63'd0, req}, 64'd0);
        @(posedge clk); #1;

        // 1: LDR, zero-wait
        wait_cfg = 0;
        push_bus(1'b0, 16'h1002, 16'h0, 2'b11, 1'b1);
        push_load(1'b1, 16'hBEEF);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1002, 16'h0, 0, 0, 16'h0);

        // 2: STR, three wait states
        wait_cfg = 3;
        push_bus(1'b1, 16'h2000, 16'h1234, 2'b11, 1'b1);
        push_load(1'b0, 16'h0);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h1234, 0, 3, 16'h0);

        // 3: LDB high byte, then STB high byte
        wait_cfg = 0;
        push_bus(1'b0, 16'h3001, 16'h0, 2'b00, 1'b0);
        push_load(1'b1, 16'hFF80);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h0, 0, 0, 16'h0);
        push_bus(1'b1, 16'h3001, 16'hABAB, 2'b10, 1'b1);
        push_load(1'b0, 16'h0);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h00AB, 0, 0, 16'h0);

        // 4: LDI, one wait state on each access
        wait_cfg = 1;
        push_bus(1'b0, 16'h4000, 16'h0, 2'b11, 1'b1);
        push_bus(1'b0, 16'h5000, 16'h0, 2'b11, 1'b1);
        push_load(1'b1, 16'h7777);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0, 0, 3, 16'h0);

        // 5: STI with pointer 0x6000, advance held low 2 cycles -> HOLD
        wait_cfg = 0;
        mem[4] = 16'h6000;
        push_bus(1'b0, 16'h4000, 16'h0, 2'b11, 1'b1);
        push_bus(1'b1, 16'h6000, 16'hCAFE, 2'b11, 1'b1);
        push_load(1'b0, 16'h0);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 16'hCAFE, 2, 1, 16'h1111);
        @(negedge clk);
        check("post_hold_noreq", {63'd0, req}, 64'd0);
        @(posedge clk); #1;

        // 6: reset while IND waits for the second response
        wait_cfg = 2;
        mem[4] = 16'h5000;
        push_bus(1'b0, 16'h4000, 16'h0, 2'b11, 1'b1);
        valid_i = 1'b1; mem_read_i = 1'b1; is_ldi_i = 1'b1; addr_i = 16'h4000;
        advance_i = 1'b0; done = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_ind_read", {63'd0, mif.dmem_read}, 64'd0);
        check("rst_ind_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; is_ldi_i = 1'b0; advance_i = 1'b1;
        prev_pending = 1'b0;
        @(negedge clk);
        check("after_rst_stall", {63'd0, stall_o}, 64'd0);
        check("after_rst_load", {48'd0, load_data_o}, 64'd0);
        check("after_rst_noreq", {63'd0, req}, 64'd0);
        check("ind_first_seen", {63'd0, done}, 64'd0);
        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        check("load_q_empty", 64'(load_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
